// File: rtl/uart_pkg.sv
// Shared UART definitions: state encodings, oversample default and line levels
// used by both the transmitter and the receiver.
package uart_pkg;

  localparam int unsigned UART_OVERSAMPLE = 16;
  localparam int unsigned UART_BITCNT_W   = 4;

  localparam logic LINE_IDLE  = 1'b1;
  localparam logic LINE_START = 1'b0;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

  typedef enum logic [1:0] {
    RX_START = 2'd0,
    RX_DATA  = 2'd1,
    RX_STOP  = 2'd2
  } rx_state_e;

endpackage

// File: rtl/uart_transmitter.sv
// UART transmitter, LSB first, paced by the shared oversample baud enable, with a
// one-entry holding register so consecutive frames can run without an idle bit.
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned OVERSAMPLE = UART_OVERSAMPLE
) (
  input  logic                 clk_50m,
  input  logic                 rst,
  input  logic                 clken,
  input  logic [DATA_BITS-1:0] din,
  input  logic                 wr_en,
  output logic                 wr_ready,
  output logic                 tx,
  output logic                 tx_busy
);

  localparam int unsigned STOP_TICKS = OVERSAMPLE * STOP_BITS;
  localparam int unsigned TICK_W     = (STOP_TICKS > 1) ? $clog2(STOP_TICKS) : 1;

  localparam logic [TICK_W-1:0]        BIT_LAST  = TICK_W'(OVERSAMPLE - 1);
  localparam logic [TICK_W-1:0]        STOP_LAST = TICK_W'(STOP_TICKS - 1);
  localparam logic [UART_BITCNT_W-1:0] DATA_LAST = UART_BITCNT_W'(DATA_BITS - 1);

  tx_state_e                state_q, state_d;
  logic [TICK_W-1:0]        tick_q, tick_d;
  logic [UART_BITCNT_W-1:0] bitpos_q, bitpos_d;
  logic [DATA_BITS-1:0]     shift_q, shift_d;
  logic [DATA_BITS-1:0]     hold_q, hold_d;
  logic                     hold_valid_q, hold_valid_d;
  logic                     tx_q, tx_d;
  logic                     tx_busy_q, tx_busy_d;

  // Holding register is the only source of back-pressure.
  assign wr_ready = ~hold_valid_q;
  assign tx       = tx_q;
  assign tx_busy  = tx_busy_q;

  always_comb begin
    state_d      = state_q;
    tick_d       = tick_q;
    bitpos_d     = bitpos_q;
    shift_d      = shift_q;
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    tx_d         = tx_q;

    // Host write; cannot collide with a hold-to-shift transfer since both need opposite hold_valid.
    if (wr_en && !hold_valid_q) begin
      hold_d       = din;
      hold_valid_d = 1'b1;
    end

    if (clken) begin
      unique case (state_q)
        TX_IDLE: begin
          tx_d = LINE_IDLE;
          if (hold_valid_q) begin
            shift_d      = hold_q;
            hold_valid_d = 1'b0;
            tick_d       = '0;
            bitpos_d     = '0;
            state_d      = TX_START;
            tx_d         = LINE_START;
          end
        end

        TX_START: begin
          if (tick_q == BIT_LAST) begin
            tick_d   = '0;
            bitpos_d = '0;
            state_d  = TX_DATA;
            tx_d     = shift_q[0];
          end else begin
            tick_d = tick_q + TICK_W'(1);
          end
        end

        TX_DATA: begin
          if (tick_q == BIT_LAST) begin
            tick_d = '0;
            if (bitpos_q == DATA_LAST) begin
              state_d = TX_STOP;
              tx_d    = LINE_IDLE;
            end else begin
              bitpos_d = bitpos_q + UART_BITCNT_W'(1);
              shift_d  = shift_q >> 1;
              tx_d     = shift_d[0];
            end
          end else begin
            tick_d = tick_q + TICK_W'(1);
          end
        end

        TX_STOP: begin
          if (tick_q == STOP_LAST) begin
            tick_d = '0;
            // Chain straight into the next start bit when a byte is already waiting.
            if (hold_valid_q) begin
              shift_d      = hold_q;
              hold_valid_d = 1'b0;
              bitpos_d     = '0;
              state_d      = TX_START;
              tx_d         = LINE_START;
            end else begin
              state_d = TX_IDLE;
              tx_d    = LINE_IDLE;
            end
          end else begin
            tick_d = tick_q + TICK_W'(1);
          end
        end

        default: begin
          state_d = TX_IDLE;
          tx_d    = LINE_IDLE;
        end
      endcase
    end

    tx_busy_d = (state_d != TX_IDLE) | hold_valid_d;
  end

  // Reset abandons any frame in flight and discards the held byte.
  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      state_q      <= TX_IDLE;
      tick_q       <= '0;
      bitpos_q     <= '0;
      shift_q      <= '0;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      tx_q         <= LINE_IDLE;
      tx_busy_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      tick_q       <= tick_d;
      bitpos_q     <= bitpos_d;
      shift_q      <= shift_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      tx_q         <= tx_d;
      tx_busy_q    <= tx_busy_d;
    end
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// Self-checking bench for uart_transmitter: a behavioural receiver on tx pops a
// scoreboard of expected bytes; directed tests cover timing, back-pressure and reset.
module tb_uart_transmitter;

  localparam int OS  = 16;
  localparam int FRM = OS * 10;

  logic       clk_50m = 1'b0;
  logic       rst     = 1'b1;
  logic       clken   = 1'b0;
  logic [7:0] din     = 8'h00;
  logic       wr_en   = 1'b0;
  logic       wr_ready;
  logic       tx;
  logic       tx_busy;

  int checks = 0;
  int errors = 0;
  int clk_div = 1;
  int div_cnt = 0;

  logic [7:0] exp_q[$];
  int         start_q[$];
  int         gtick = 0;
  int         frames_rx = 0;
  logic       m_active = 1'b0;
  int         m_t = 0;
  logic [7:0] m_byte = 8'h00;
  logic       ck;

  uart_transmitter dut (
    .clk_50m (clk_50m),
    .rst     (rst),
    .clken   (clken),
    .din     (din),
    .wr_en   (wr_en),
    .wr_ready(wr_ready),
    .tx      (tx),
    .tx_busy (tx_busy)
  );

  initial forever #10 clk_50m = ~clk_50m;

  // Baud enable: every cycle when clk_div<=1, otherwise one pulse per clk_div cycles.
  initial begin
    forever begin
      @(negedge clk_50m);
      if (clk_div <= 1) begin
        clken = 1'b1;
      end else begin
        div_cnt = (div_cnt + 1) % clk_div;
        clken   = (div_cnt == 0);
      end
    end
  end

  task automatic check_eq(input string tag, input int got, input int expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, expv);
    end
  endtask

  // Behavioural receiver: mid-bit sampling counted in baud ticks.
  initial begin
    forever begin
      @(posedge clk_50m);
      ck = clken;
      #1;
      if (rst) begin
        m_active = 1'b0;
      end else begin
        if (ck) gtick++;
        if (!m_active) begin
          if (ck && tx == 1'b0) begin
            m_active = 1'b1;
            m_t      = 0;
            start_q.push_back(gtick);
          end
        end else if (ck) begin
          m_t++;
          if (m_t % OS == OS / 2) begin
            if (m_t / OS == 0) begin
              check_eq("rx_start_bit", int'(tx), 0);
            end else if (m_t / OS <= 8) begin
              m_byte[m_t/OS-1] = tx;
            end else begin
              check_eq("rx_stop_bit", int'(tx), 1);
              check_eq("sb_nonempty", int'(exp_q.size() != 0), 1);
              if (exp_q.size() != 0) check_eq("rx_byte", int'(m_byte), int'(exp_q.pop_front()));
              frames_rx++;
              m_active = 1'b0;
            end
          end
        end
      end
    end
  end

  task automatic write_byte(input logic [7:0] b);
    @(negedge clk_50m);
    din   = b;
    wr_en = 1'b1;
    @(negedge clk_50m);
    wr_en = 1'b0;
  endtask

  task automatic wait_ready(input int budget);
    int n = 0;
    while (wr_ready !== 1'b1 && n < budget) begin
      @(negedge clk_50m);
      n++;
    end
    check_eq("ready_seen", int'(wr_ready), 1);
  endtask

  task automatic wait_tx_low(input int budget);
    int n = 0;
    while (tx !== 1'b0 && n < budget) begin
      @(negedge clk_50m);
      n++;
    end
    check_eq("tx_low_seen", int'(tx), 0);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (tx_busy !== 1'b0 && n < budget) begin
      @(negedge clk_50m);
      n++;
    end
    check_eq("idle_seen", int'(tx_busy), 0);
  endtask

  // Called on the first sample after tx falls; checks every cycle of the frame.
  task automatic check_levels(input logic [7:0] b, input int cpb);
    logic lvl;
    for (int k = 0; k < 10; k++) begin
      lvl = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b[k-1];
      for (int c = 0; c < cpb; c++) begin
        if (k != 0 || c != 0) @(negedge clk_50m);
        check_eq($sformatf("lvl_bit%0d", k), int'(tx), int'(lvl));
      end
    end
    check_eq("busy_last_stop", int'(tx_busy), 1);
    @(negedge clk_50m);
    check_eq("busy_dropped", int'(tx_busy), 0);
  endtask

  initial begin
    int f0;
    int bad;

    // Reset state
    repeat (3) @(negedge clk_50m);
    check_eq("rst_tx", int'(tx), 1);
    check_eq("rst_wr_ready", int'(wr_ready), 1);
    check_eq("rst_busy", int'(tx_busy), 0);
    rst = 1'b0;
    repeat (4) @(negedge clk_50m);
    check_eq("idle_tx", int'(tx), 1);

    // 0x55 with clken every cycle: 16 cycles per level, busy drops at tick 160
    exp_q.push_back(8'h55);
    write_byte(8'h55);
    wait_tx_low(50);
    check_levels(8'h55, OS);

    // Back-to-back 0xA5, 0x3C: contiguous frames, 320 busy ticks
    start_q.delete();
    f0 = frames_rx;
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h3C);
    write_byte(8'hA5);
    wait_ready(50);
    write_byte(8'h3C);
    wait_idle(2000);
    check_eq("b2b_frames", frames_rx - f0, 2);
    if (start_q.size() == 2) begin
      check_eq("b2b_gap", start_q[1] - start_q[0], FRM);
      check_eq("b2b_busy_ticks", gtick - start_q[0], 2 * FRM);
    end else begin
      check_eq("b2b_starts", start_q.size(), 2);
    end

    // Write while holding register full is dropped
    f0 = frames_rx;
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    write_byte(8'h11);
    wait_ready(50);
    write_byte(8'h22);
    check_eq("full_wr_ready", int'(wr_ready), 0);
    write_byte(8'h33);
    wait_idle(2000);
    check_eq("drop_frames", frames_rx - f0, 2);
    check_eq("drop_sb_empty", exp_q.size(), 0);

    // clken every 4 cycles: 64 cycles per bit
    clk_div = 4;
    exp_q.push_back(8'hC3);
    write_byte(8'hC3);
    wait_tx_low(200);
    check_levels(8'hC3, 4 * OS);
    clk_div = 1;
    repeat (4) @(negedge clk_50m);

    // Reset during bit 3 of 0xF0 with a byte also held
    write_byte(8'hF0);
    wait_ready(50);
    write_byte(8'h0F);
    wait_tx_low(50);
    repeat (OS * 4 + 4) @(negedge clk_50m);
    check_eq("pre_rst_tx_bit3", int'(tx), 0);
    check_eq("pre_rst_busy", int'(tx_busy), 1);
    #1 rst = 1'b1;
    #1;
    check_eq("async_rst_tx", int'(tx), 1);
    check_eq("async_rst_ready", int'(wr_ready), 1);
    check_eq("async_rst_busy", int'(tx_busy), 0);
    repeat (2) @(negedge clk_50m);
    rst = 1'b0;
    start_q.delete();
    bad = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk_50m);
      if (tx !== 1'b1 || tx_busy !== 1'b0) bad++;
    end
    check_eq("post_rst_quiet", bad, 0);
    check_eq("post_rst_no_start", start_q.size(), 0);

    // Loopback 0x00, 0xFF, 0x81 back-to-back
    start_q.delete();
    f0 = frames_rx;
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'h81);
    write_byte(8'h00);
    wait_ready(50);
    write_byte(8'hFF);
    wait_ready(400);
    write_byte(8'h81);
    wait_idle(2000);
    check_eq("loop_frames", frames_rx - f0, 3);
    if (start_q.size() == 3) begin
      check_eq("loop_gap1", start_q[1] - start_q[0], FRM);
      check_eq("loop_gap2", start_q[2] - start_q[1], FRM);
    end else begin
      check_eq("loop_starts", start_q.size(), 3);
    end
    check_eq("final_sb_empty", exp_q.size(), 0);
    check_eq("final_tx", int'(tx), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
